// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and flag helpers for the multi-cycle execute ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2
  } alu_state_e;

  // Signed overflow of an addition from operand/result sign bits; for
  // subtraction pass the inverted B sign.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Combinational single-cycle unit: add/sub/logic/compare with carry and overflow.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] res_o,
  output logic             carry_o,
  output logic             ovf_o
);

  logic [WIDTH:0] add_w;
  logic [WIDTH:0] sub_w;

  assign add_w = {1'b0, a_i} + {1'b0, b_i};
  assign sub_w = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};

  // Shifts, MUL and illegal codes fall to the default: all zeros.
  always_comb begin
    res_o   = '0;
    carry_o = 1'b0;
    ovf_o   = 1'b0;
    case (op_i)
      OP_ADD: begin
        res_o   = add_w[WIDTH-1:0];
        carry_o = add_w[WIDTH];
        ovf_o   = add_ovf(a_i[WIDTH-1], b_i[WIDTH-1], add_w[WIDTH-1]);
      end
      OP_SUB: begin
        res_o   = sub_w[WIDTH-1:0];
        carry_o = sub_w[WIDTH];
        ovf_o   = add_ovf(a_i[WIDTH-1], ~b_i[WIDTH-1], sub_w[WIDTH-1]);
      end
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      OP_SLT:  res_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SLTU: res_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle execute ALU: single-cycle ops via alu_comb, iterative shifter and
// shift-add multiplier behind an EN/DONE/BUSY handshake.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic             CK_REF,
  input  logic             RST_N,
  input  logic             ALU_EN,
  input  logic [3:0]       OP_VAL,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] OUT,
  output logic             ZERO_FLAG,
  output logic             CARRY_FLAG,
  output logic             OVERFLOW_FLAG,
  output logic             ALU_DONE,
  output logic             ALU_BUSY
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int CW      = SHAMT_W + 1;  // counter must also hold WIDTH for MUL
  localparam logic [CW-1:0] STEP  = CW'(SHIFT_STEP);
  localparam logic [CW-1:0] NBITS = CW'(WIDTH);

  alu_state_e state_q, state_d;

  logic [WIDTH-1:0]   out_q, out_d, sh_q, sh_d, mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         shop_q, shop_d;
  logic               zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d, done_q, done_d;

  logic [WIDTH-1:0]   cmb_res, sh_nxt;
  logic               cmb_c, cmb_v, is_shift, shamt_nz;
  logic [CW-1:0]      step;
  logic [2*WIDTH-1:0] acc_nxt;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .op_i(OP_VAL), .a_i(A), .b_i(B), .res_o(cmb_res), .carry_o(cmb_c), .ovf_o(cmb_v)
  );

  assign is_shift = (OP_VAL == OP_SLL) || (OP_VAL == OP_SRL) || (OP_VAL == OP_SRA);
  assign shamt_nz = |B[SHAMT_W-1:0];
  assign step     = (cnt_q < STEP) ? cnt_q : STEP;
  assign acc_nxt  = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    case (shop_q)
      2'b00:   sh_nxt = sh_q << step;
      2'b01:   sh_nxt = sh_q >> step;
      default: sh_nxt = $signed(sh_q) >>> step;
    endcase
  end

  always_ff @(posedge CK_REF) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ALU_EN) begin
        if (is_shift && shamt_nz) state_d = ST_SHIFT;
        else if (OP_VAL == OP_MUL) state_d = ST_MUL;
      end
      ST_SHIFT: if (cnt_q <= STEP) state_d = ST_IDLE;
      ST_MUL:   if (cnt_q == CW'(1)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_d    = out_q;   zero_d   = zero_q;  carry_d = carry_q;  ovf_d = ovf_q;
    done_d   = 1'b0;    sh_d     = sh_q;    shop_d  = shop_q;   cnt_d = cnt_q;
    acc_d    = acc_q;   mcand_d  = mcand_q; mplier_d = mplier_q;
    case (state_q)
      ST_IDLE: if (ALU_EN) begin
        if (is_shift && shamt_nz) begin
          sh_d   = A;
          shop_d = OP_VAL[1:0];
          cnt_d  = {1'b0, B[SHAMT_W-1:0]};
        end else if (OP_VAL == OP_MUL) begin
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, A};
          mplier_d = B;
          cnt_d    = NBITS;
        end else begin
          // Zero-amount shifts pass A through; everything else comes from alu_comb.
          out_d   = is_shift ? A : cmb_res;
          carry_d = is_shift ? 1'b0 : cmb_c;
          ovf_d   = is_shift ? 1'b0 : cmb_v;
          zero_d  = is_shift ? (A == '0) : (cmb_res == '0);
          done_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        sh_d  = sh_nxt;
        cnt_d = cnt_q - step;
        if (cnt_q <= STEP) begin
          out_d = sh_nxt; zero_d = (sh_nxt == '0); carry_d = 1'b0; ovf_d = 1'b0;
          done_d = 1'b1;
        end
      end
      ST_MUL: begin
        acc_d    = acc_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          out_d   = acc_nxt[WIDTH-1:0];
          zero_d  = (acc_nxt[WIDTH-1:0] == '0);
          carry_d = 1'b0;
          ovf_d   = |acc_nxt[2*WIDTH-1:WIDTH];
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CK_REF) begin
    if (!RST_N) begin
      out_q <= '0; zero_q <= 1'b0; carry_q <= 1'b0; ovf_q <= 1'b0; done_q <= 1'b0;
      sh_q <= '0; shop_q <= '0; cnt_q <= '0; acc_q <= '0; mcand_q <= '0; mplier_q <= '0;
    end else begin
      out_q <= out_d; zero_q <= zero_d; carry_q <= carry_d; ovf_q <= ovf_d; done_q <= done_d;
      sh_q <= sh_d; shop_q <= shop_d; cnt_q <= cnt_d;
      acc_q <= acc_d; mcand_q <= mcand_d; mplier_q <= mplier_d;
    end
  end

  assign OUT           = out_q;
  assign ZERO_FLAG     = zero_q;
  assign CARRY_FLAG    = carry_q;
  assign OVERFLOW_FLAG = ovf_q;
  assign ALU_DONE      = done_q;
  assign ALU_BUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_seq.sv
// Directed plus randomized checks of alu_seq (WIDTH=32, SHIFT_STEP=4) against
// an arithmetic reference model.
module tb_alu_seq;

  logic        CK_REF = 1'b0;
  logic        RST_N, ALU_EN;
  logic [3:0]  OP_VAL;
  logic [31:0] A, B, OUT;
  logic        ZERO_FLAG, CARRY_FLAG, OVERFLOW_FLAG, ALU_DONE, ALU_BUSY;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] last_out = '0;

  always #5 CK_REF = ~CK_REF;

  alu_seq #(.WIDTH(32), .SHIFT_STEP(4)) dut (
    .CK_REF(CK_REF), .RST_N(RST_N), .ALU_EN(ALU_EN), .OP_VAL(OP_VAL), .A(A), .B(B),
    .OUT(OUT), .ZERO_FLAG(ZERO_FLAG), .CARRY_FLAG(CARRY_FLAG),
    .OVERFLOW_FLAG(OVERFLOW_FLAG), .ALU_DONE(ALU_DONE), .ALU_BUSY(ALU_BUSY)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: result, flags and busy length from plain wide arithmetic.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] o, output logic c, output logic v,
                                output int nb);
    longint sa, sb, sr;
    logic [63:0] w;
    int sh;
    sa = longint'($signed(a)); sb = longint'($signed(b)); sh = int'(b[4:0]);
    o = '0; c = 1'b0; v = 1'b0; nb = 0;
    case (op)
      4'd1: begin
        w = 64'(a) + 64'(b); o = w[31:0]; c = w[32];
        sr = sa + sb; v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'd2: begin
        o = a - b; c = (a >= b);
        sr = sa - sb; v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'd3: o = a & b;
      4'd4: o = a | b;
      4'd5: o = a ^ b;
      4'd6: o = (sa < sb) ? 32'd1 : 32'd0;
      4'd7: o = (a < b) ? 32'd1 : 32'd0;
      4'd8: begin o = a << sh; nb = (sh + 3) / 4; end
      4'd9: begin o = a >> sh; nb = (sh + 3) / 4; end
      4'd10: begin o = $signed(a) >>> sh; nb = (sh + 3) / 4; end
      4'd11: begin w = 64'(a) * 64'(b); o = w[31:0]; v = |w[63:32]; nb = 32; end
      default: o = '0;
    endcase
  endfunction

  // Issue one op (called at a negedge, with the DUT idle or in a DONE cycle) and
  // check it; returns at the negedge of the DONE cycle so a follow-up can chain.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] eo;
    logic ec, ev;
    int enb, nb;
    bit hold;
    model(op, a, b, eo, ec, ev, enb);
    ALU_EN = 1'b1; OP_VAL = op; A = a; B = b;
    @(posedge CK_REF); @(negedge CK_REF);
    ALU_EN = 1'b0; OP_VAL = 4'($urandom); A = $urandom; B = $urandom;
    nb = 0; hold = 1'b1;
    while (!ALU_DONE && nb < 100) begin
      if (!ALU_BUSY || OUT !== last_out) hold = 1'b0;
      nb++;
      @(negedge CK_REF);
    end
    chk({tag, " busy"}, 64'(nb), 64'(enb));
    chk({tag, " done"}, 64'(ALU_DONE), 64'd1);
    chk({tag, " out"}, 64'(OUT), 64'(eo));
    chk({tag, " bzcv"}, {60'd0, ALU_BUSY, ZERO_FLAG, CARRY_FLAG, OVERFLOW_FLAG},
        {60'd0, 1'b0, (eo == 32'd0), ec, ev});
    if (enb > 0) chk({tag, " hold"}, 64'(hold), 64'd1);
    last_out = eo;
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    RST_N = 1'b0; ALU_EN = 1'b0; OP_VAL = '0; A = '0; B = '0;
    repeat (3) @(negedge CK_REF);
    chk("reset", {OUT, ZERO_FLAG, CARRY_FLAG, OVERFLOW_FLAG, ALU_DONE, ALU_BUSY}, 64'd0);
    RST_N = 1'b1;
    @(negedge CK_REF);

    run_op("add_wrap", 4'd1, 32'hFFFF_FFFF, 32'd1);
    @(negedge CK_REF);
    chk("done_single_pulse", 64'(ALU_DONE), 64'd0);
    run_op("sub_ovf", 4'd2, 32'h8000_0000, 32'd1);
    run_op("sltu_b2b", 4'd7, 32'd1, 32'd2);
    run_op("sra31", 4'd10, 32'h8000_0000, 32'd31);
    @(negedge CK_REF);
    chk("done_multi_pulse", 64'(ALU_DONE), 64'd0);
    run_op("sra0", 4'd10, 32'h8000_0000, 32'd0);
    run_op("mul_ovf", 4'd11, 32'h0001_0000, 32'h0001_0000);
    run_op("mul_small", 4'd11, 32'd1234, 32'd5678);
    run_op("illegal0", 4'd0, 32'h1234_5678, 32'h9abc_def0);
    run_op("illegalF", 4'd15, 32'hFFFF_FFFF, 32'h1);

    // Request during BUSY must be ignored; OUT holds until the MUL completes.
    ALU_EN = 1'b1; OP_VAL = 4'd11; A = 32'd300; B = 32'd7;
    @(posedge CK_REF); @(negedge CK_REF);
    OP_VAL = 4'd1; A = 32'd100; B = 32'd200;
    repeat (3) begin
      chk("busy_ignore", {31'd0, ALU_BUSY, OUT}, {31'd0, 1'b1, last_out});
      @(negedge CK_REF);
    end
    ALU_EN = 1'b0;
    for (int i = 0; i < 40 && !ALU_DONE; i++) @(negedge CK_REF);
    chk("mul_after_ignore", {31'd0, ALU_DONE, OUT}, {31'd0, 1'b1, 32'd2100});
    last_out = 32'd2100;
    run_op("add_in_done", 4'd1, 32'd5, 32'd6);

    // Synchronous reset in the middle of a MUL discards it.
    ALU_EN = 1'b1; OP_VAL = 4'd11; A = 32'd77; B = 32'd99;
    @(posedge CK_REF); @(negedge CK_REF);
    ALU_EN = 1'b0;
    repeat (8) @(negedge CK_REF);
    chk("busy_before_rst", 64'(ALU_BUSY), 64'd1);
    RST_N = 1'b0;
    @(negedge CK_REF);
    RST_N = 1'b1;
    chk("mid_rst", {OUT, ZERO_FLAG, CARRY_FLAG, OVERFLOW_FLAG, ALU_DONE, ALU_BUSY}, 64'd0);
    repeat (40) begin
      @(negedge CK_REF);
      if (ALU_DONE || ALU_BUSY) break;
    end
    chk("no_done_after_rst", {62'd0, ALU_DONE, ALU_BUSY}, 64'd0);
    last_out = '0;
    run_op("add_after_rst", 4'd1, 32'd9000, 32'd8192);

    for (int i = 0; i < 80; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000 | 32'($urandom_range(0, 3));
      run_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb);
      if ($urandom_range(0, 2) == 0) @(negedge CK_REF);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
